vga_rect_fill: RTL

Rectangle-fill engine that drives the framebuffer write port of the VGA display block (`we`, `haddr`, `vaddr`, `wdata`). It accepts one fill command at a time through a valid/ready handshake and clips the rectangle to the visible framebuffer. It then emits one pixel write per clock in raster order. It sits between the CPU's memory-mapped graphics registers and the display block, replacing per-pixel software stores for clears and solid boxes.

---
 rtl/vga_rect_fill_if.sv | 36 +++
 rtl/vga_rect_fill.sv | 124 ++++++++++++
 2 files changed

// File: rtl/vga_rect_fill_if.sv
// ---------------------------------------------------------------------------
// vga_rect_fill_if
// Bundles the fill-command handshake and the framebuffer write port of the
// rectangle-fill engine.
//   cmd_valid/cmd_ready          : command handshake
//   cmd_x/cmd_y/cmd_w/cmd_h      : rectangle origin and size (10 bit each)
//   cmd_color                    : RGB444 fill colour
//   busy/done                    : engine status, done is a one-cycle pulse
//   we/haddr/vaddr/wdata         : framebuffer write port
// Modports: slave = the engine, master = command issuer / write-port observer.
// ---------------------------------------------------------------------------
interface vga_rect_fill_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x;
    logic [9:0]  cmd_y;
    logic [9:0]  cmd_w;
    logic [9:0]  cmd_h;
    logic [11:0] cmd_color;
    logic        busy;
    logic        done;
    logic        we;
    logic [9:0]  haddr;
    logic [9:0]  vaddr;
    logic [11:0] wdata;

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        output cmd_ready, busy, done, we, haddr, vaddr, wdata
    );

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        input  cmd_ready, busy, done, we, haddr, vaddr, wdata
    );
endinterface

// File: rtl/vga_rect_fill.sv
// ---------------------------------------------------------------------------
// vga_rect_fill
// Rectangle-fill engine: accepts one fill command, clips it to the visible
// HSIZE x VSIZE framebuffer and emits one pixel write per clock in raster
// order.
//   rclk : clock (display block write-port clock)
//   rst  : asynchronous active-low reset
//   bus  : vga_rect_fill_if.slave (command handshake, status, write port)
// ---------------------------------------------------------------------------
module vga_rect_fill #(
    parameter int unsigned HSIZE = 320,
    parameter int unsigned VSIZE = 240
) (
    input  logic            rclk,
    input  logic            rst,
    vga_rect_fill_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLIP = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [10:0] HLIM = 11'(HSIZE);
    localparam logic [10:0] VLIM = 11'(VSIZE);

    state_t      r_state;
    state_t      w_next;

    logic [9:0]  r_x0;
    logic [9:0]  r_y0;
    logic [10:0] r_xe;      // exclusive right edge, clamped in CLIP
    logic [10:0] r_ye;      // exclusive bottom edge, clamped in CLIP
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic [11:0] r_color;

    logic        w_accept;
    logic [10:0] w_xe_clip;
    logic [10:0] w_ye_clip;
    logic        w_empty;
    logic        w_x_last;
    logic        w_y_last;

    assign w_accept  = (r_state == IDLE) && bus.cmd_valid;
    assign w_xe_clip = (r_xe > HLIM) ? HLIM : r_xe;
    assign w_ye_clip = (r_ye > VLIM) ? VLIM : r_ye;
    // Zero size and fully off-screen both collapse to "origin not left of edge".
    assign w_empty   = ({1'b0, r_x0} >= w_xe_clip) || ({1'b0, r_y0} >= w_ye_clip);
    // Only used in FILL, where r_xe/r_ye are already clamped and non-zero.
    assign w_x_last  = ({1'b0, r_x} == (r_xe - 11'd1));
    assign w_y_last  = ({1'b0, r_y} == (r_ye - 11'd1));

    always_ff @(posedge rclk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = CLIP;
            CLIP: w_next = w_empty ? DONE : FILL;
            FILL: if (w_x_last && w_y_last) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge rclk or negedge rst) begin
        if (!rst) begin
            r_x0    <= '0;
            r_y0    <= '0;
            r_xe    <= '0;
            r_ye    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_color <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x0    <= bus.cmd_x;
                        r_y0    <= bus.cmd_y;
                        r_color <= bus.cmd_color;
                        r_xe    <= {1'b0, bus.cmd_x} + {1'b0, bus.cmd_w};
                        r_ye    <= {1'b0, bus.cmd_y} + {1'b0, bus.cmd_h};
                    end
                end
                CLIP: begin
                    r_xe <= w_xe_clip;
                    r_ye <= w_ye_clip;
                    r_x  <= r_x0;
                    r_y  <= r_y0;
                end
                FILL: begin
                    if (w_x_last) begin
                        r_x <= r_x0;
                        r_y <= r_y + 10'd1;
                    end else begin
                        r_x <= r_x + 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Write enable decodes from the state register, so an asynchronous reset
    // drops it at once.
    assign bus.cmd_ready = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = (r_state == DONE);
    assign bus.we        = (r_state == FILL);
    assign bus.haddr     = r_x;
    assign bus.vaddr     = r_y;
    assign bus.wdata     = r_color;

endmodule
